// File: rtl/postfft_pkg.sv
// postfft_pkg: shared types and constants for the post-FFT averaging RAM path
package postfft_pkg;

    localparam int AVG_DEPTH = 240;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        LAST,
        FULL
    } state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } port_t;

    // A read address is serviceable only if it lies inside the stored block
    function automatic logic addr_ok(input int addr, input int depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/avg_ram_ctrl_if.sv
// avg_ram_ctrl_if: upstream stream, two read ports and RAM-side signals of the averaging RAM controller
interface avg_ram_ctrl_if #(
    parameter int RAM_WIDTH  = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                         in_valid;
    logic signed [RAM_WIDTH-1:0]  in_data;
    logic                         in_ready;
    logic                         buf_full;
    logic                         buf_release;
    logic                         rd_req_a;
    logic                         rd_req_b;
    logic        [ADDR_WIDTH-1:0] rd_addr_a;
    logic        [ADDR_WIDTH-1:0] rd_addr_b;
    logic                         rd_gnt_a;
    logic                         rd_gnt_b;
    logic                         rd_valid_a;
    logic                         rd_valid_b;
    logic                         rd_err_a;
    logic                         rd_err_b;
    logic signed [RAM_WIDTH-1:0]  rd_data;
    logic                         ram_wre;
    logic signed [RAM_WIDTH-1:0]  ram_din;
    logic        [ADDR_WIDTH-1:0] ram_rd_addr;
    logic signed [RAM_WIDTH-1:0]  ram_dout;

    modport master (
        input  in_valid, in_data, buf_release,
        input  rd_req_a, rd_req_b, rd_addr_a, rd_addr_b,
        input  ram_dout,
        output in_ready, buf_full,
        output rd_gnt_a, rd_gnt_b, rd_valid_a, rd_valid_b, rd_err_a, rd_err_b, rd_data,
        output ram_wre, ram_din, ram_rd_addr
    );

    modport slave (
        output in_valid, in_data, buf_release,
        output rd_req_a, rd_req_b, rd_addr_a, rd_addr_b,
        output ram_dout,
        input  in_ready, buf_full,
        input  rd_gnt_a, rd_gnt_b, rd_valid_a, rd_valid_b, rd_err_a, rd_err_b, rd_data,
        input  ram_wre, ram_din, ram_rd_addr
    );

endinterface

// File: rtl/avg_ram_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, the port that did not win last gets priority on a tie
module rr_arb2
    import postfft_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    port_t rr_ptr_q, rr_ptr_d;

    // Grant selection and pointer follow-up: on a tie the port opposite rr_ptr wins
    always_comb begin
        gnt_o    = &req_i ? (rr_ptr_q == PORT_A ? 2'b10 : 2'b01) : req_i;
        rr_ptr_d = gnt_o[1] ? PORT_B : gnt_o[0] ? PORT_A : rr_ptr_q;
    end

    // Pointer register remembers the most recently granted port
    always_ff @(posedge clk) begin
        rr_ptr_q <= rst ? PORT_A : rr_ptr_d;
    end

endmodule

// File: rtl/avg_ram_ctrl.sv
// avg_ram_ctrl: fills the averaging RAM with one block, then arbitrates reads between two consumers
module avg_ram_ctrl
    import postfft_pkg::*;
#(
    parameter int RAM_WIDTH  = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = AVG_DEPTH
) (
    input logic            clk,
    input logic            rst,
    avg_ram_ctrl_if.master bus
);

    state_t                      state_q, state_d;
    logic       [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
    logic                        ram_wre_q;
    logic signed [RAM_WIDTH-1:0] ram_din_q;
    logic       [ADDR_WIDTH-1:0] ram_rd_addr_q;
    logic       [1:0]            vld_a_q, vld_b_q;
    logic                        in_ready, accept, last_acc, arb_en, ok_a, ok_b, hit_a, hit_b;
    logic       [1:0]            req, gnt;

    assign in_ready = state_q == IDLE || state_q == FILL;
    assign accept   = bus.in_valid & in_ready;
    assign last_acc = accept && fill_cnt_q == ADDR_WIDTH'(DEPTH - 1);
    assign arb_en   = state_q == FULL && !ram_wre_q;
    assign req      = {bus.rd_req_b, bus.rd_req_a} & {2{arb_en}};
    assign ok_a     = addr_ok(int'(bus.rd_addr_a), DEPTH);
    assign ok_b     = addr_ok(int'(bus.rd_addr_b), DEPTH);
    assign hit_a    = gnt[0] & ok_a;
    assign hit_b    = gnt[1] & ok_b;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (req),
        .gnt_o (gnt)
    );

    // Next state and fill counter; the DEPTH-th accept (IDLE one included) ends the fill
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = accept ? (last_acc ? '0 : fill_cnt_q + 1'b1) : fill_cnt_q;
        unique case (state_q)
            IDLE:    state_d = accept ? (last_acc ? LAST : FILL) : IDLE;
            FILL:    state_d = last_acc ? LAST : FILL;
            LAST:    state_d = FULL;
            FULL:    state_d = bus.buf_release ? IDLE : FULL;
            default: state_d = IDLE;
        endcase
    end

    // State and fill counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fill_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    // Write pipeline: the RAM sees each accepted sample one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_wre_q <= 1'b0;
            ram_din_q <= '0;
        end else begin
            ram_wre_q <= accept;
            ram_din_q <= bus.in_data;
        end
    end

    // Read pipeline: address registered at grant, valid tracks the synchronous RAM latency
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_rd_addr_q <= '0;
            vld_a_q       <= '0;
            vld_b_q       <= '0;
        end else begin
            ram_rd_addr_q <= hit_a ? bus.rd_addr_a : hit_b ? bus.rd_addr_b : ram_rd_addr_q;
            vld_a_q       <= {vld_a_q[0], hit_a};
            vld_b_q       <= {vld_b_q[0], hit_b};
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.buf_full    = state_q == FULL;
    assign bus.rd_gnt_a    = gnt[0];
    assign bus.rd_gnt_b    = gnt[1];
    assign bus.rd_err_a    = gnt[0] & ~ok_a;
    assign bus.rd_err_b    = gnt[1] & ~ok_b;
    assign bus.rd_valid_a  = vld_a_q[1];
    assign bus.rd_valid_b  = vld_b_q[1];
    assign bus.rd_data     = bus.ram_dout;
    assign bus.ram_wre     = ram_wre_q;
    assign bus.ram_din     = ram_din_q;
    assign bus.ram_rd_addr = ram_rd_addr_q;

endmodule

// File: tb/tb_avg_ram_ctrl.sv
// tb_avg_ram_ctrl: scoreboard bench for avg_ram_ctrl with a behavioural averaging RAM beside it
module tb_avg_ram_ctrl;
    import postfft_pkg::*;

    localparam int W  = 16;
    localparam int AW = 8;
    localparam int D  = 240;

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    avg_ram_ctrl_if #(.RAM_WIDTH(W), .ADDR_WIDTH(AW)) bus ();

    avg_ram_ctrl #(.RAM_WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic signed [W-1:0]  mem [D];
    logic        [AW-1:0] wcnt;

    // Averaging RAM wrapper: self-incrementing write counter, synchronous read
    always @(posedge clk) begin
        if (rst) wcnt <= '0;
        else if (bus.ram_wre) begin
            mem[wcnt] <= bus.ram_din;
            wcnt      <= (wcnt == AW'(D - 1)) ? '0 : wcnt + 1'b1;
        end
        bus.ram_dout <= mem[bus.ram_rd_addr];
    end

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   wre_cnt = 0;
    int   last_addr = 0;
    bit   tb_rr   = 1'b0;
    int   exp_mem [D];
    exp_t qa [$];
    exp_t qb [$];

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic at_neg();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (bus.ram_wre) wre_cnt++;
        if (bus.rd_valid_a) begin
            if (qa.size() == 0) check("rd_valid_a_unexpected", 1, 0);
            else begin
                e = qa.pop_front();
                check("rd_data_a", int'(bus.rd_data), e.data);
                check("rd_lat_a", cyc, e.cyc);
            end
        end
        if (bus.rd_valid_b) begin
            if (qb.size() == 0) check("rd_valid_b_unexpected", 1, 0);
            else begin
                e = qb.pop_front();
                check("rd_data_b", int'(bus.rd_data), e.data);
                check("rd_lat_b", cyc, e.cyc);
            end
        end
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            at_neg();
            at_pos();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.rd_req_a = 1'b0;
        bus.rd_req_b = 1'b0;
        bus.buf_release = 1'b0;
        at_neg();
        check("buf_full_in_rst", bus.buf_full, 0);
        at_pos();
        rst = 1'b0;
        tb_rr = 1'b0;
        qa.delete();
        qb.delete();
        at_neg();
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_buf_full", bus.buf_full, 0);
        check("rst_ram_wre", bus.ram_wre, 0);
        check("rst_rd_addr", bus.ram_rd_addr, 0);
        check("rst_rd_valid", {bus.rd_valid_a, bus.rd_valid_b}, 0);
        at_pos();
    endtask

    task automatic fill(input int base, input int n, input bit toggle);
        int acc = 0;
        int guard = 0;
        bit ph = 1'b0;
        bit rdy_ok = 1'b1;
        while (acc < n && guard < 2000) begin
            bus.in_valid = toggle ? ph : 1'b1;
            bus.in_data  = W'(base + acc);
            ph = ~ph;
            at_neg();
            if (!bus.in_ready) rdy_ok = 1'b0;
            if (bus.in_valid && bus.in_ready) begin
                exp_mem[acc] = base + acc;
                acc++;
            end
            at_pos();
            guard++;
        end
        bus.in_valid = 1'b0;
        check("fill_in_ready", rdy_ok, 1);
        check("fill_accepts", acc, n);
    endtask

    task automatic fill_block(input int base, input bit toggle);
        int w0 = wre_cnt;
        fill(base, D, toggle);
        at_neg();
        check("last_in_ready", bus.in_ready, 0);
        check("last_buf_full", bus.buf_full, 0);
        check("last_ram_wre", bus.ram_wre, 1);
        at_pos();
        at_neg();
        check("full_buf_full", bus.buf_full, 1);
        check("full_in_ready", bus.in_ready, 0);
        check("wre_pulses", wre_cnt - w0, D);
        at_pos();
    endtask

    task automatic rd_cycle(input bit ra, input int aa, input bit rb, input int ab, input bit en);
        bit ga, gb;
        bus.rd_req_a  = ra;
        bus.rd_addr_a = AW'(aa);
        bus.rd_req_b  = rb;
        bus.rd_addr_b = AW'(ab);
        ga = en && ra && (!rb || tb_rr);
        gb = en && rb && (!ra || !tb_rr);
        if (ga) tb_rr = 1'b0;
        if (gb) tb_rr = 1'b1;
        at_neg();
        check("gnt_a", bus.rd_gnt_a, ga);
        check("gnt_b", bus.rd_gnt_b, gb);
        check("err_a", bus.rd_err_a, ga && aa >= D);
        check("err_b", bus.rd_err_b, gb && ab >= D);
        if (ga && aa < D) begin
            qa.push_back(exp_t'{data: exp_mem[aa], cyc: cyc + 2});
            last_addr = aa;
        end
        if (gb && ab < D) begin
            qb.push_back(exp_t'{data: exp_mem[ab], cyc: cyc + 2});
            last_addr = ab;
        end
        at_pos();
        bus.rd_req_a = 1'b0;
        bus.rd_req_b = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.buf_release = 1'b0;
        bus.rd_req_a    = 1'b0;
        bus.rd_req_b    = 1'b0;
        bus.rd_addr_a   = '0;
        bus.rd_addr_b   = '0;
        do_reset();

        rd_cycle(1'b1, 3, 1'b1, 4, 1'b0);
        fill_block(0, 1'b0);

        bus.buf_release = 1'b1;
        idle(1);
        bus.buf_release = 1'b0;
        at_neg();
        check("release_buf_full", bus.buf_full, 0);
        check("release_in_ready", bus.in_ready, 1);
        at_pos();
        fill_block(0, 1'b1);
        rd_cycle(1'b1, 0, 1'b0, 0, 1'b1);
        rd_cycle(1'b1, 1, 1'b0, 0, 1'b1);
        rd_cycle(1'b1, 239, 1'b0, 0, 1'b1);
        idle(3);

        bus.in_valid = 1'b1;
        bus.in_data  = W'(77);
        at_neg();
        check("full_stall_in_ready", bus.in_ready, 0);
        at_pos();
        bus.in_valid = 1'b0;
        at_neg();
        check("full_stall_no_wre", bus.ram_wre, 0);
        at_pos();
        repeat (6) rd_cycle(1'b1, 10, 1'b1, 20, 1'b1);
        idle(3);

        rd_cycle(1'b0, 0, 1'b1, 240, 1'b1);
        rd_cycle(1'b0, 0, 1'b1, 255, 1'b1);
        at_neg();
        check("err_rd_addr_held", bus.ram_rd_addr, last_addr);
        at_pos();
        idle(3);

        bus.buf_release = 1'b1;
        rd_cycle(1'b1, 7, 1'b0, 0, 1'b1);
        bus.buf_release = 1'b0;
        fill_block(1000, 1'b0);
        rd_cycle(1'b0, 0, 1'b1, 5, 1'b1);
        idle(3);

        bus.buf_release = 1'b1;
        idle(1);
        bus.buf_release = 1'b0;
        fill(2000, 100, 1'b0);
        do_reset();
        fill_block(3000, 1'b0);
        rd_cycle(1'b1, 0, 1'b0, 0, 1'b1);
        rd_cycle(1'b0, 0, 1'b1, 239, 1'b1);
        idle(4);

        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
